// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the registered immediate-decode stage.
//   - IMM_* : 3-bit immediate format selectors driven by the control unit
//   - XLEN_NARROW / XLEN_WIDE and xlen_is_legal() : the two supported widths
//   - stage_state_e : occupancy state of the output/skid register pair
// ----------------------------------------------------------------------------
package imm_pkg;

   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_U    = 3'b011;
   localparam logic [2:0] IMM_J    = 3'b100;
   localparam logic [2:0] IMM_Z    = 3'b101;
   localparam logic [2:0] IMM_SH   = 3'b110;
   localparam logic [2:0] IMM_NONE = 3'b111;

   localparam int XLEN_NARROW = 32;
   localparam int XLEN_WIDE   = 64;

   function automatic bit xlen_is_legal(input int xlen);
      return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
   endfunction

   // ST_EMPTY: nothing held; ST_ONE: output register full;
   // ST_FULL: output and skid registers both full (skid build only).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } stage_state_e;

endpackage : imm_pkg

// File: rtl/imm_extract.sv
// ----------------------------------------------------------------------------
// imm_extract
// Purely combinational immediate extractor.
//   inst     in  32    instruction word (opcode bits [6:0] are not used)
//   imm_type in  3     format selector (IMM_* from imm_pkg)
//   imm      out XLEN  decoded immediate
//   err      out 1     shift amount does not fit a 32-bit datapath
// Every format is first built at 64 bits and then truncated to XLEN, so the
// U format is sign-extended at XLEN=64 and naturally exact at XLEN=32.
// ----------------------------------------------------------------------------
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_type,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   logic        sign;
   logic [63:0] wide;
   logic        unused_opcode;

   assign sign          = inst[31];
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path through the case leaves it unassigned (no latch).
      wide = '0;
      err  = 1'b0;
      case (imm_type)
         IMM_I:  wide = {{52{sign}}, inst[31:20]};
         IMM_S:  wide = {{52{sign}}, inst[31:25], inst[11:7]};
         IMM_B:  wide = {{51{sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:  wide = {{32{sign}}, inst[31:12], 12'b0};
         IMM_J:  wide = {{43{sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_Z:  wide = {59'b0, inst[19:15]};
         IMM_SH: begin
            if (XLEN == XLEN_WIDE) begin
               wide = {58'b0, inst[25:20]};
            end else begin
               wide = {59'b0, inst[24:20]};
               // shamt[5] set is only meaningful on a 64-bit datapath
               err  = inst[25];
            end
         end
         default: wide = '0;  // IMM_NONE
      endcase
   end

   assign imm = wide[XLEN-1:0];

endmodule : imm_extract

// File: rtl/imm_decode_stage.sv
// ----------------------------------------------------------------------------
// imm_decode_stage
// Registered immediate-decode stage between fetch/decode and register read.
// The immediate is decoded on the input side and registered, giving one cycle
// of latency. A valid/ready handshake lets decode stall without losing
// instructions; SKID=1 adds a second entry so inReady can be a flop output.
//   clk        in   1      rising-edge clock
//   rstN       in   1      asynchronous active-low reset
//   flush      in   1      synchronous flush, discards all held entries
//   inValid    in   1      upstream holds a valid instruction
//   inReady    out  1      stage can accept this cycle
//   inInst     in   32     instruction word
//   inImmType  in   3      format selector
//   inTag      in   TAG_W  sideband tag
//   outValid   out  1      outImm/outTag/outErr are valid
//   outReady   in   1      downstream accepts this cycle
//   outImm     out  XLEN   decoded immediate
//   outTag     out  TAG_W  tag of the entry on outImm
//   outErr     out  1      illegal shift amount for XLEN=32
// ----------------------------------------------------------------------------
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8,
   parameter int SKID  = 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             flush,
   input  logic             inValid,
   output logic             inReady,
   input  logic [31:0]      inInst,
   input  logic [2:0]       inImmType,
   input  logic [TAG_W-1:0] inTag,
   output logic             outValid,
   input  logic             outReady,
   output logic [XLEN-1:0]  outImm,
   output logic [TAG_W-1:0] outTag,
   output logic             outErr
);

   generate
      if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Input-side decode
   // ------------------------------------------------------------------
   logic [XLEN-1:0] dec_imm;
   logic            dec_err;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst     (inInst),
      .imm_type (inImmType),
      .imm      (dec_imm),
      .err      (dec_err)
   );

   // ------------------------------------------------------------------
   // Occupancy FSM
   // ------------------------------------------------------------------
   stage_state_e state_q, state_d;
   logic         in_xfer, out_xfer;
   logic         load_out_from_in, load_out_from_skid, load_skid;

   assign outValid = (state_q != ST_EMPTY);
   assign in_xfer  = inValid & inReady;
   assign out_xfer = outValid & outReady;

   always_ff @(posedge clk or negedge rstN) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge values of the others.
      if (!rstN) state_q <= ST_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d            = state_q;
      load_out_from_in   = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid          = 1'b0;
      if (flush) begin
         // flush wins over any transfer; the offered input is dropped
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  load_out_from_in = 1'b1;
                  state_d          = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  // new entry bypasses the skid straight into the output
                  load_out_from_in = 1'b1;
               end else if (in_xfer) begin
                  // only reachable with SKID=1: no-skid inReady needs outReady
                  load_skid = 1'b1;
                  state_d   = ST_FULL;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  load_out_from_skid = 1'b1;
                  state_d            = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // inReady: flop output with a skid, combinational without
   // ------------------------------------------------------------------
   generate
      if (SKID != 0) begin : g_skid_ready
         logic in_ready_q;
         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) in_ready_q <= 1'b1;
            else       in_ready_q <= (state_d != ST_FULL);
         end
         assign inReady = in_ready_q;
      end else begin : g_comb_ready
         assign inReady = ~outValid | outReady;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;

   // NOTE: the skid payload has no reset; it is only ever read while the
   // FSM says it is full, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_imm <= dec_imm;
         skid_tag <= inTag;
         skid_err <= dec_err;
      end
   end

   // Output payload is cleared on reset but otherwise only changes on a load,
   // which keeps it stable while the stage is stalled.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         outImm <= '0;
         outTag <= '0;
         outErr <= 1'b0;
      end else if (load_out_from_in) begin
         outImm <= dec_imm;
         outTag <= inTag;
         outErr <= dec_err;
      end else if (load_out_from_skid) begin
         outImm <= skid_imm;
         outTag <= skid_tag;
         outErr <= skid_err;
      end
   end

endmodule : imm_decode_stage
